dcache_ctrl: RTL

- Sequencing FSM for the data cache.
- Accepts datapath load/store requests and reports hits.
- On a miss: writes back a dirty victim block word-by-word, fills the new block from memory, then retries the lookup.
- On halt: scans every set/way, writes back all dirty blocks, then raises flushed.
- Sits between the datapath, the tag/data SRAM plus replacement logic, and the single-word memory port.

---
 rtl/dcache_ctrl_pkg.sv | 29 ++
 rtl/dcache_line_cnt.sv | 56 +++++
 rtl/dcache_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_pkg.sv
// Shared data-cache types: controller state encoding and the default
// address split used by the cache controller and its environment.
package dcache_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        FETCH,
        FLUSH_SCAN,
        FLUSH_WB,
        DONE
    } dctrl_state_t;

    localparam int unsigned DC_WORDS  = 2;
    localparam int unsigned DC_SETS   = 8;
    localparam int unsigned DC_WAYS   = 2;
    localparam int unsigned DC_WORD_W = $clog2(DC_WORDS);
    localparam int unsigned DC_IDX_W  = $clog2(DC_SETS);
    localparam int unsigned DC_WAY_W  = (DC_WAYS > 1) ? $clog2(DC_WAYS) : 1;
    localparam int unsigned DC_TAG_W  = 32 - 2 - DC_WORD_W - DC_IDX_W;

    typedef struct packed {
        logic [DC_TAG_W-1:0]  tag;
        logic [DC_IDX_W-1:0]  idx;
        logic [DC_WORD_W-1:0] word;
        logic [1:0]           byte_off;
    } dcache_addr_t;

endpackage

// File: rtl/dcache_line_cnt.sv
// Word / set / way counters used by the cache controller for block
// transfers and the flush scan.
module dcache_line_cnt
    import dcache_ctrl_pkg::*;
#(
    parameter int unsigned WORDS = DC_WORDS,
    parameter int unsigned SETS  = DC_SETS,
    parameter int unsigned WAYS  = DC_WAYS,
    localparam int unsigned WORD_W = $clog2(WORDS),
    localparam int unsigned IDX_W  = $clog2(SETS),
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              word_clr,
    input  logic              word_inc,
    input  logic              line_clr,
    input  logic              line_inc,
    output logic [WORD_W-1:0] wcnt,
    output logic [IDX_W-1:0]  scnt,
    output logic [WAY_W-1:0]  way_cnt,
    output logic              last_word,
    output logic              last_line
);

    logic last_way;

    assign last_word = (wcnt == WORD_W'(WORDS - 1));
    assign last_way  = (way_cnt == WAY_W'(WAYS - 1));
    assign last_line = last_way && (scnt == IDX_W'(SETS - 1));

    // Word counter wraps naturally at WORDS.
    always_ff @(posedge CLK) begin
        if (RST || word_clr) begin
            wcnt <= '0;
        end else if (word_inc) begin
            wcnt <= wcnt + WORD_W'(1);
        end
    end

    // Line counter saturates at the last line; the scan exits to DONE there.
    always_ff @(posedge CLK) begin
        if (RST || line_clr) begin
            scnt    <= '0;
            way_cnt <= '0;
        end else if (line_inc && !last_line) begin
            if (last_way) begin
                way_cnt <= '0;
                scnt    <= scnt + IDX_W'(1);
            end else begin
                way_cnt <= way_cnt + WAY_W'(1);
            end
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Data cache sequencing FSM: hit service, dirty write-back, block fill
// and halt-time flush of every dirty line.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int unsigned WORDS = DC_WORDS,
    parameter int unsigned SETS  = DC_SETS,
    parameter int unsigned WAYS  = DC_WAYS,
    localparam int unsigned WORD_W = $clog2(WORDS),
    localparam int unsigned IDX_W  = $clog2(SETS),
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int unsigned TAG_W  = 32 - 2 - WORD_W - IDX_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              halt,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [31:0]       dmemaddr,
    output logic              dhit,
    output logic              flushed,
    input  logic              hit,
    input  logic [WAY_W-1:0]  hit_way,
    input  logic [WAY_W-1:0]  victim_way,
    input  logic              line_dirty,
    input  logic [TAG_W-1:0]  line_tag,
    input  logic [31:0]       line_word,
    output logic [IDX_W-1:0]  sram_idx,
    output logic [WAY_W-1:0]  sram_way,
    output logic [WORD_W-1:0] sram_word,
    output logic              sramWEN,
    output logic              fill_sel,
    output logic              set_dirty,
    output logic              fill_done,
    output logic              clr_dirty,
    output logic              lru_touch,
    output logic              dREN,
    output logic              dWEN,
    output logic [31:0]       daddr,
    output logic [31:0]       dstore,
    input  logic              dwait,
    input  logic [31:0]       dload
);

    dctrl_state_t state_q, state_d;

    logic [TAG_W-1:0]  req_tag_q;
    logic [IDX_W-1:0]  req_idx_q;
    logic [WAY_W-1:0]  vic_q;
    logic              miss_latch;

    logic [WORD_W-1:0] req_word;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              req;

    logic              word_clr, word_inc, line_clr, line_inc;
    logic [WORD_W-1:0] wcnt;
    logic [IDX_W-1:0]  scnt;
    logic [WAY_W-1:0]  way_cnt;
    logic              last_word, last_line;

    // Byte offset and fill data are consumed by the datapath/SRAM, not here.
    logic              pass_unused;
    assign pass_unused = ^{dload, dmemaddr[1:0]};

    assign req_word = dmemaddr[2 +: WORD_W];
    assign req_idx  = dmemaddr[2 + WORD_W +: IDX_W];
    assign req_tag  = dmemaddr[31 -: TAG_W];
    assign req      = dmemREN || dmemWEN;
    assign dstore   = line_word;

    dcache_line_cnt #(
        .WORDS (WORDS),
        .SETS  (SETS),
        .WAYS  (WAYS)
    ) u_cnt (
        .CLK       (CLK),
        .RST       (RST),
        .word_clr  (word_clr),
        .word_inc  (word_inc),
        .line_clr  (line_clr),
        .line_inc  (line_inc),
        .wcnt      (wcnt),
        .scnt      (scnt),
        .way_cnt   (way_cnt),
        .last_word (last_word),
        .last_line (last_line)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            req_tag_q <= '0;
            req_idx_q <= '0;
            vic_q     <= '0;
        end else begin
            state_q <= state_d;
            if (miss_latch) begin
                req_tag_q <= req_tag;
                req_idx_q <= req_idx;
                vic_q     <= victim_way;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        dhit       = 1'b0;
        flushed    = 1'b0;
        lru_touch  = 1'b0;
        sramWEN    = 1'b0;
        fill_sel   = 1'b0;
        set_dirty  = 1'b0;
        fill_done  = 1'b0;
        clr_dirty  = 1'b0;
        dREN       = 1'b0;
        dWEN       = 1'b0;
        daddr      = '0;
        sram_idx   = req_idx_q;
        sram_way   = vic_q;
        sram_word  = wcnt;
        word_clr   = 1'b0;
        word_inc   = 1'b0;
        line_clr   = 1'b0;
        line_inc   = 1'b0;
        miss_latch = 1'b0;

        unique case (state_q)
            IDLE: begin
                sram_idx  = req_idx;
                sram_word = req_word;
                sram_way  = hit ? hit_way : victim_way;
                if (halt) begin
                    line_clr = 1'b1;
                    state_d  = FLUSH_SCAN;
                end else if (req) begin
                    if (hit) begin
                        dhit      = 1'b1;
                        lru_touch = 1'b1;
                        if (dmemWEN) begin
                            sramWEN   = 1'b1;
                            set_dirty = 1'b1;
                        end
                    end else begin
                        miss_latch = 1'b1;
                        word_clr   = 1'b1;
                        state_d    = line_dirty ? WB : FETCH;
                    end
                end
            end
            WB: begin
                dWEN  = 1'b1;
                daddr = {line_tag, req_idx_q, wcnt, 2'b00};
                if (!dwait) begin
                    word_inc = 1'b1;
                    if (last_word) state_d = FETCH;
                end
            end
            FETCH: begin
                dREN  = 1'b1;
                daddr = {req_tag_q, req_idx_q, wcnt, 2'b00};
                if (!dwait) begin
                    sramWEN  = 1'b1;
                    fill_sel = 1'b1;
                    word_inc = 1'b1;
                    if (last_word) begin
                        fill_done = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            FLUSH_SCAN: begin
                sram_idx = scnt;
                sram_way = way_cnt;
                if (line_dirty) begin
                    word_clr = 1'b1;
                    state_d  = FLUSH_WB;
                end else if (last_line) begin
                    state_d = DONE;
                end else begin
                    line_inc = 1'b1;
                end
            end
            FLUSH_WB: begin
                sram_idx = scnt;
                sram_way = way_cnt;
                dWEN     = 1'b1;
                daddr    = {line_tag, scnt, wcnt, 2'b00};
                if (!dwait) begin
                    word_inc = 1'b1;
                    if (last_word) begin
                        clr_dirty = 1'b1;
                        if (last_line) begin
                            state_d = DONE;
                        end else begin
                            line_inc = 1'b1;
                            state_d  = FLUSH_SCAN;
                        end
                    end
                end
            end
            DONE: begin
                flushed = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
